// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, ALU op codes,
// controller state encoding and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned CntW = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeq     = 4'd8,
    StAddiEx  = 4'd9,
    StAndiEx  = 4'd10,
    StImmWb   = 4'd11,
    StJump    = 4'd12,
    StJal     = 4'd13
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait-state counter shared by FETCH and MEMRD; done flags the cycle on
// which memory data is valid.
module mem_wait_counter
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [CntW-1:0] WaitMax = CntW'(MEM_WAIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WaitMax);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// and decodes every datapath mux select and enable from the current state.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       jrsel,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       cnt_en, cnt_clr, cnt_done;
  logic       pc_write, pc_write_cond;

  assign cnt_en  = (state_q == StFetch) || (state_q == StMemRd);
  assign cnt_clr = cnt_en && cnt_done;

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .done(cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:   state_d = cnt_done ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OP_RTYPE:     state_d = StRtypeEx;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBeq;
          OP_ADDI:      state_d = StAddiEx;
          OP_ANDI:      state_d = StAndiEx;
          OP_J:         state_d = StJump;
          OP_JAL:       state_d = StJal;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (op_q == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   state_d = cnt_done ? StMemWb : StMemRd;
      StRtypeEx: state_d = jrsel ? StFetch : StRtypeWb;
      StAddiEx:  state_d = StImmWb;
      StAndiEx:  state_d = StImmWb;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    pc_src        = PC_SRC_ALU;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = cnt_done;
        pc_write  = cnt_done;
      end
      StDecode:  alu_src_b = SRC_B_IMM_SH;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
        // jr resolves here: jump to A and skip writeback
        if (jrsel) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_REG;
        end
      end
      StRtypeWb: begin
        reg_dst   = REG_DST_RD;
        reg_write = 1'b1;
      end
      StBeq: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      StAndiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_AND;
      end
      StImmWb:   reg_write = 1'b1;
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      StJal: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REG_DST_R31;
        mem_to_reg = M2R_PC;
      end
      default: ;
    endcase
    // Strobes drop in the very cycle reset is seen, not one edge later
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = '0;
      mem_to_reg    = '0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      alu_op        = '0;
      pc_src        = '0;
    end
  end

  assign pc_en   = pc_write | (pc_write_cond & zero);
  assign state_o = rst ? StFetch : state_q;

endmodule
